// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, arbiter FSM encoding, default datapath width.
// Pure definitions, no logic.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op, a, b -> result plus illegal-op flag; zero latency, no flow control.
// Unknown op codes yield a zero result with illegal set.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU; response two cycles after accept, one op in flight.
// req_ready only in IDLE to the winner; result held on resp_* until the granted requester takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_op,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic                 resp_err,
    output logic                 busy
);

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic            gnt_q, gnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            win;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .result  (alu_res),
        .illegal (alu_ill)
    );

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req_ready   = '0;
        resp_valid  = '0;
        // prio_q names the requester that wins a tie; a lone requester always wins.
        win = (req_valid[0] && req_valid[1]) ? prio_q : req_valid[1];
        case (state_q)
            ST_IDLE: begin
                if (|req_valid && !rst) begin
                    req_ready[win] = 1'b1;
                    state_d        = ST_EXEC;
                    gnt_d          = win;
                    prio_d         = ~win;
                    op_d           = req_op[int'(win)*4 +: 4];
                    a_d            = req_a[int'(win)*XLEN +: XLEN];
                    b_d            = req_b[int'(win)*XLEN +: XLEN];
                end
            end
            ST_EXEC: begin
                resp_data_d = alu_res;
                resp_err_d  = alu_ill;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[gnt_q] = !rst;
                if (resp_ready[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized transactions against a queue-free
// transaction-level model of round-robin arbitration and ALU arithmetic.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.XLEN(32), .NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU: returns {err, data}, built from plain arithmetic.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        logic [31:0] bias;
        bias = 32'h8000_0000;
        ext  = {{32{a[31]}}, a} >> b[4:0];
        case (op)
            4'd1:    return {1'b0, a + b};
            4'd2:    return {1'b0, a - b};
            4'd3:    return {1'b0, a << b[4:0]};
            4'd4:    return {1'b0, ((a ^ bias) < (b ^ bias)) ? 32'd1 : 32'd0};
            4'd5:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'd6:    return {1'b0, a ^ b};
            4'd7:    return {1'b0, a >> b[4:0]};
            4'd8:    return {1'b0, ext[31:0]};
            4'd9:    return {1'b0, a | b};
            4'd10:   return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[idx*4 +: 4]   = op;
        req_a[idx*32 +: 32]  = a;
        req_b[idx*32 +: 32]  = b;
    endtask

    // Observes one transaction: grant seen, response latency, response contents; then accepts it.
    task automatic collect(input bit drop, output logic [1:0] g, output logic [31:0] d,
                           output logic e, output logic [1:0] rv, output int lat);
        #1;
        g = req_ready;
        tick();
        if (drop) req_valid = req_valid & ~g;
        lat = 1;
        while (resp_valid == 2'b00 && lat < 8) begin
            tick();
            lat++;
        end
        if (resp_valid == 2'b00) lat = -1;
        rv = resp_valid;
        d  = resp_data;
        e  = resp_err;
        resp_ready = rv;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        resp_ready = '0;
        req_valid  = 2'b11;
        set_req(0, 4'd1, 32'd1, 32'd2);
        set_req(1, 4'd2, 32'd3, 32'd4);
        tick();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b want 0", busy); end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_add();
        logic [1:0] g, rv; logic [31:0] d; logic e; int lat;
        apply_reset();
        set_req(0, 4'd1, 32'd5, 32'd7);
        req_valid = 2'b01;
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL add_grant got %b want 01", g); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
        checks++; if (rv !== 2'b01) begin errors++; $display("FAIL add_resp_valid got %b want 01", rv); end
        checks++; if (d !== 32'd12) begin errors++; $display("FAIL add_data got %h want 0000000c", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err got %b want 0", e); end
        checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin errors++; $display("FAIL add_idle busy %b resp_valid %b want 0 00", busy, resp_valid); end
    endtask

    task automatic test_both_after_reset();
        logic [1:0] g, rv; logic [31:0] d; logic e; int lat;
        apply_reset();
        set_req(0, 4'd2, 32'd3, 32'd5);
        set_req(1, 4'd8, 32'h8000_0000, 32'd4);
        req_valid = 2'b11;
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (g !== 2'b01 || rv !== 2'b01) begin errors++; $display("FAIL both_first grant %b resp %b want 01 01", g, rv); end
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL both_sub_data got %h want fffffffe", d); end
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (g !== 2'b10 || rv !== 2'b10) begin errors++; $display("FAIL both_second grant %b resp %b want 10 10", g, rv); end
        checks++; if (d !== 32'hF800_0000) begin errors++; $display("FAIL both_sra_data got %h want f8000000", d); end
    endtask

    task automatic test_alternate();
        logic [1:0] g, rv, want; logic [31:0] d; logic e; int lat;
        logic [32:0] exp0, exp1;
        apply_reset();
        set_req(0, 4'd6, $urandom(), $urandom());
        set_req(1, 4'd4, $urandom(), $urandom());
        exp0 = ref_alu(req_op[3:0], req_a[31:0], req_b[31:0]);
        exp1 = ref_alu(req_op[7:4], req_a[63:32], req_b[63:32]);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            collect(1'b0, g, d, e, rv, lat);
            checks++; if (g !== want || rv !== want) begin errors++; $display("FAIL alternate_grant_%0d grant %b resp %b want %b", i, g, rv, want); end
            checks++; if (d !== ((i % 2 == 0) ? exp0[31:0] : exp1[31:0])) begin errors++; $display("FAIL alternate_data_%0d got %h want %h", i, d, (i % 2 == 0) ? exp0[31:0] : exp1[31:0]); end
        end
        req_valid = '0;
    endtask

    task automatic test_illegal();
        logic [1:0] g, rv; logic [31:0] d; logic e; int lat;
        apply_reset();
        set_req(1, 4'b1111, 32'h1234_5678, 32'h1111_1111);
        req_valid = 2'b10;
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (g !== 2'b10 || rv !== 2'b10) begin errors++; $display("FAIL illegal_grant grant %b resp %b want 10 10", g, rv); end
        checks++; if (d !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL illegal_result data %h err %b want 0 1", d, e); end
        set_req(1, 4'd1, 32'h1234_5678, 32'h1111_1111);
        req_valid = 2'b10;
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (d !== 32'h2345_6789 || e !== 1'b0 || lat !== 2) begin errors++; $display("FAIL illegal_next data %h err %b lat %0d want 23456789 0 2", d, e, lat); end
    endtask

    task automatic test_stall();
        logic [1:0] g, rv; logic [31:0] d, d0; logic e; int lat;
        logic [32:0] exp0, exp1;
        apply_reset();
        set_req(0, 4'd6, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        set_req(1, 4'd9, 32'h0000_00F0, 32'h0000_0F00);
        exp0 = ref_alu(4'd6, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        exp1 = ref_alu(4'd9, 32'h0000_00F0, 32'h0000_0F00);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        tick();
        d0 = resp_data;
        checks++; if (d0 !== exp0[31:0] || resp_valid !== 2'b01) begin errors++; $display("FAIL stall_first data %h valid %b want %h 01", d0, resp_valid, exp0[31:0]); end
        for (int i = 0; i < 5; i++) begin
            resp_ready = 2'b10;
            tick();
            checks++;
            if ({resp_valid, req_ready, busy, resp_data} !== {2'b01, 2'b00, 1'b1, d0}) begin
                errors++;
                $display("FAIL stall_hold_%0d valid %b ready %b busy %b data %h want 01 00 1 %h", i, resp_valid, req_ready, busy, resp_data, d0);
            end
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_held_req got %b want 10", req_ready); end
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (g !== 2'b10 || d !== exp1[31:0]) begin errors++; $display("FAIL stall_second grant %b data %h want 10 %h", g, d, exp1[31:0]); end
    endtask

    task automatic test_abort();
        logic [1:0] g, rv; logic [31:0] d; logic e; int lat;
        int seen;
        apply_reset();
        set_req(0, 4'd1, 32'd100, 32'd23);
        set_req(1, 4'd2, 32'd50, 32'd8);
        req_valid = 2'b01;
        collect(1'b1, g, d, e, rv, lat);
        checks++; if (d !== 32'd123) begin errors++; $display("FAIL abort_pre data %h want 0000007b", d); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL abort_rr_grant got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({req_ready, resp_valid, resp_data, resp_err, busy} !== 38'd0) begin
            errors++;
            $display("FAIL abort_outputs ready %b valid %b data %h err %b busy %b want all 0", req_ready, resp_valid, resp_data, resp_err, busy);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid !== 2'b00) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_resp got %0d cycles with resp_valid want 0", seen); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL abort_prio_reset got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0]  pend, exp_g;
        logic [3:0]  pop [2];
        logic [31:0] pa [2];
        logic [31:0] pb [2];
        logic        prio, w;
        logic [32:0] expv;
        int          stall;
        apply_reset();
        pend = 2'b00;
        prio = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pop[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
                    pa[i] = pick_val();
                    pb[i] = pick_val();
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1; pop[0] = 4'd3; pa[0] = pick_val(); pb[0] = pick_val();
            end
            for (int i = 0; i < 2; i++) set_req(i, pop[i], pa[i], pb[i]);
            req_valid = pend;
            #1;
            w     = (pend == 2'b11) ? prio : pend[1];
            exp_g = 2'b01 << w;
            expv  = ref_alu(pop[w], pa[w], pb[w]);
            checks++; if (req_ready !== exp_g || busy !== 1'b0) begin errors++; $display("FAIL rand_grant_%0d ready %b busy %b want %b 0", t, req_ready, busy, exp_g); end
            tick();
            pend[w]   = 1'b0;
            prio      = ~w;
            req_valid = pend;
            #1;
            checks++; if (req_ready !== 2'b00 || busy !== 1'b1 || resp_valid !== 2'b00) begin errors++; $display("FAIL rand_exec_%0d ready %b busy %b valid %b want 00 1 00", t, req_ready, busy, resp_valid); end
            tick();
            checks++;
            if (resp_valid !== exp_g || resp_data !== expv[31:0] || resp_err !== expv[32]) begin
                errors++;
                $display("FAIL rand_resp_%0d op %h valid %b data %h err %b want %b %h %b", t, pop[w], resp_valid, resp_data, resp_err, exp_g, expv[31:0], expv[32]);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                resp_ready = ~exp_g & 2'($urandom_range(0, 3));
                tick();
                checks++;
                if (resp_valid !== exp_g || resp_data !== expv[31:0] || req_ready !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_stall_%0d valid %b data %h ready %b want %b %h 00", t, resp_valid, resp_data, req_ready, exp_g, expv[31:0]);
                end
            end
            resp_ready = exp_g | (~exp_g & 2'($urandom_range(0, 3)));
            tick();
            resp_ready = 2'b00;
            checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rand_done_%0d valid %b busy %b want 00 0", t, resp_valid, busy); end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        test_reset();
        test_add();
        test_both_after_reset();
        test_alternate();
        test_illegal();
        test_stall();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter NREQ, fixed 2, meaning number of requesters; index 0 = execute pipe, 1 = address-gen/debug port.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_op  input  NREQ*4  per-requester 4-bit ALU operation code (package encoding).
REQ-008 req_a, req_b  input  NREQ*XLEN each  per-requester operands.
REQ-009 resp_valid  output  NREQ  per-requester result valid.
REQ-010 resp_ready  input  NREQ  per-requester result accept.
REQ-011 resp_data  output  XLEN  result, shared bus; meaningful only where resp_valid is set.
REQ-012 resp_err  output  1  illegal-operation flag, qualified by resp_valid.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Op encoding SHALL be: 0001 ADD, 0010 SUB, 0011 SLL, 0100 SLT, 0101 SLTU, 0110 XOR, 0111 SRL, 1000 SRA, 1001 OR, 1010 AND; 0000 and 1011-1111 illegal.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-016 IDLE: req_ready SHALL be driven high (combinationally) only to the grant winner among valid requesters; handshake on req_valid&req_ready latches op, a, b and grant index; next state EXEC.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valids, winner is the requester not granted last; after reset, requester 0 has priority.
REQ-018 A single valid requester SHALL be granted in the same cycle regardless of priority pointer.
REQ-019 Priority pointer SHALL update only on an accepted handshake.
REQ-020 EXEC: lasts exactly 1 cycle; result from latched operands registered into resp_data; next state RESP.
REQ-021 Shifts SHALL use req_b[4:0] as amount; SLT signed, SLTU unsigned compare, result 1 or 0 zero-extended; ADD/SUB wrap modulo 2^XLEN.
REQ-022 Illegal op SHALL produce resp_data = 0, resp_err = 1; no other side effect.
REQ-023 RESP: resp_valid asserted only for the granted index; resp_data/resp_err SHALL hold stable until resp_ready for that index; on handshake next state IDLE.
REQ-024 Request-to-response latency SHALL be 2 cycles (accept cycle N, resp_valid at N+2); back-to-back throughput one result per 3 cycles.
REQ-025 req_ready SHALL be 0 in EXEC and RESP; requests held valid SHALL not be lost and are arbitrated on return to IDLE.
REQ-026 resp_ready on a non-granted index SHALL be ignored.

Reset
REQ-027 On rst: state IDLE, req_ready 0, resp_valid 0, resp_data 0, resp_err 0, busy 0, priority pointer to requester 0.
REQ-028 rst asserted in EXEC or RESP SHALL abort the transaction; no response is ever issued for it.
REQ-029 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 4-bit op localparams, the FSM state encoding, and the XLEN default.
REQ-031 Combinational execute SHALL be a sub-module alu_core (op, a, b -> result, illegal), reused by the execute pipe.

Verification
REQ-032 Req0 ADD a=5 b=7 accepted at cycle N -> resp_valid[0] at N+2, resp_data=12, resp_err=0.
REQ-033 Both valid in IDLE after reset, req0 SUB 3-5, req1 SRA 0x80000000>>4 -> req0 first 0xFFFFFFFE, then req1 0xF8000000.
REQ-034 Both held valid for 4 transactions -> grants alternate 0,1,0,1.
REQ-035 Req1 op 1111 -> resp_data=0, resp_err=1; next request served normally.
REQ-036 resp_ready[0] held low 5 cycles -> resp_data stable, req_ready all 0, busy=1 throughout.
REQ-037 rst pulsed in EXEC -> next cycle all outputs at reset values, no resp_valid ever for aborted request.
